// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate unit: opcodes, FSM state
// encoding and a width helper for the shift-amount counter.
package shift_pkg;

  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_SHRA = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; used to size the remaining-bits counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // True for the five opcodes this unit actually executes.
  function automatic logic is_shift_op(input logic [4:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_SHR, OP_SHL, OP_SHRA, OP_ROR, OP_ROL: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/param_shift_unit_if.sv
// Request/response bundle between the ALU control and the shift unit.
// The master issues start/OP/operands; the slave (the shift unit) answers.
interface param_shift_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [4:0]       OP;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             illegal_op;

  modport master (
    output start, OP, a_in, b_in,
    input  result, busy, done, illegal_op
  );

  modport slave (
    input  start, OP, a_in, b_in,
    output result, busy, done, illegal_op
  );
endinterface

// File: rtl/shift_step.sv
// One combinational shift/rotate step: moves value by 'amount' bit
// positions according to op. Unknown opcodes pass the value through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic [CW-1:0]    amount,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] shifted
);

  localparam logic [CW-1:0] WL = CW'(WIDTH);

  // Select the shifted/rotated form; an amount of 0 leaves value unchanged
  // because shifting by WIDTH yields zero for the wrapped-in half.
  always_comb begin
    shifted = value;
    case (op)
      OP_SHR:  shifted = value >> amount;
      OP_SHL:  shifted = value << amount;
      OP_SHRA: shifted = $signed(value) >>> amount;
      OP_ROR:  shifted = (value >> amount) | (value << (WL - amount));
      OP_ROL:  shifted = (value << amount) | (value >> (WL - amount));
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/param_shift_unit.sv
// Multi-cycle shift/rotate unit beside the ALU; shifts up to STEP bits per
// clock and pulses done when result is valid.
// Optional build macro: SHIFT_AMT_SAT_EN -- take the shift amount from the
// full b_in so SHR/SHL/SHRA by WIDTH or more saturate in one SHIFT cycle.
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic               Clock,
  input logic               Clear,
  param_shift_unit_if.slave bus
);

  localparam int LW = clog2(WIDTH);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] step_out;
  logic [WIDTH-1:0] load_val;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    step_k;
  logic [CW-1:0]    load_rem;
  logic [CW-1:0]    n_mod;
  logic [4:0]       op_q;
  logic             busy_q;
  logic             done_q;
  logic             illegal_q;

  assign n_mod  = {1'b0, bus.b_in[LW-1:0]};
  assign step_k = (remaining < STEP_C) ? remaining : STEP_C;

`ifdef SHIFT_AMT_SAT_EN
  logic sat_hit;
  // Oversized non-rotate amounts are resolved at accept time: the work
  // register is preloaded with the saturated value and zero steps remain.
  assign sat_hit  = ((bus.b_in >> LW) != '0) && (bus.OP != OP_ROR) && (bus.OP != OP_ROL);
  assign load_val = !sat_hit ? bus.a_in :
                    (bus.OP == OP_SHRA) ? {WIDTH{bus.a_in[WIDTH-1]}} : '0;
  assign load_rem = sat_hit ? '0 : n_mod;
`else
  assign load_val = bus.a_in;
  assign load_rem = n_mod;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .value   (work),
    .amount  (step_k),
    .op      (op_q),
    .shifted (step_out)
  );

  // Control FSM with registered outputs; Clear overrides any operation.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state     <= S_IDLE;
      work      <= '0;
      remaining <= '0;
      op_q      <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
          if (bus.start) begin
            if (is_shift_op(bus.OP)) begin
              op_q      <= bus.OP;
              work      <= load_val;
              remaining <= load_rem;
              illegal_q <= 1'b0;
              busy_q    <= 1'b1;
              state     <= S_SHIFT;
            end else begin
              result_q  <= bus.a_in;
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work      <= step_out;
          remaining <= remaining - step_k;
          if (remaining <= STEP_C) begin
            result_q <= step_out;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// Scoreboard bench for param_shift_unit: two instances (STEP=1 and STEP=4)
// receive the same requests; expected result, illegal flag and latency are
// queued at issue and compared when each instance pulses done.
module tb_param_shift_unit;

  localparam logic [4:0] T_SHR  = 5'b00111;
  localparam logic [4:0] T_SHL  = 5'b01000;
  localparam logic [4:0] T_SHRA = 5'b01001;
  localparam logic [4:0] T_ROR  = 5'b01010;
  localparam logic [4:0] T_ROL  = 5'b01011;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic Clock = 1'b0;
  logic Clear;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 Clock = ~Clock;

  param_shift_unit_if #(.WIDTH(32)) bus1 ();
  param_shift_unit_if #(.WIDTH(32)) bus4 ();

  param_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (.Clock(Clock), .Clear(Clear), .bus(bus1));
  param_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (.Clock(Clock), .Clear(Clear), .bus(bus4));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [4:0] op);
    return (op == T_SHR) || (op == T_SHL) || (op == T_SHRA) || (op == T_ROR) || (op == T_ROL);
  endfunction

  function automatic bit saturates(input logic [4:0] op, input logic [31:0] b);
`ifdef SHIFT_AMT_SAT_EN
    return (b >= 32) && (op == T_SHR || op == T_SHL || op == T_SHRA);
`else
    return (op == 5'b11111) && (b == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelResult(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    int n;
    logic [31:0] r;
    n = int'(b % 32);
    if (!legal(op)) return a;
    if (saturates(op, b)) return (op == T_SHRA) ? {32{a[31]}} : 32'h0;
    case (op)
      T_SHR:   r = a >> n;
      T_SHL:   r = a << n;
      T_SHRA:  r = $signed(a) >>> n;
      T_ROR:   r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      default: r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
    endcase
    return r;
  endfunction

  function automatic int modelLatency(input logic [4:0] op, input logic [31:0] b, input int step);
    int n;
    n = int'(b % 32);
    if (!legal(op)) return 0;
    if (saturates(op, b)) return 1;
    if (n == 0) return 1;
    return (n + step - 1) / step;
  endfunction

  task automatic driveInputs(input logic s, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    bus1.start = s; bus1.OP = op; bus1.a_in = a; bus1.b_in = b;
    bus4.start = s; bus4.OP = op; bus4.a_in = a; bus4.b_in = b;
  endtask

  // Issue one request to both units, then watch for their done pulses.
  // With poke set, a conflicting start is raised while both are busy.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit poke);
    exp_t e;
    bit   seen1 = 1'b0;
    bit   seen4 = 1'b0;
    bit   overlap = 1'b0;
    e.res = modelResult(op, a, b);
    e.ill = !legal(op);
    e.lat = modelLatency(op, b, 1);
    q1.push_back(e);
    e.lat = modelLatency(op, b, 4);
    q4.push_back(e);
    @(negedge Clock);
    driveInputs(1'b1, op, a, b);
    for (int c = 0; c < 100 && !(seen1 && seen4); c++) begin
      @(negedge Clock);
      if (c == 0) driveInputs(1'b0, op, ~a, ~b);
      if (poke && c == 2) driveInputs(1'b1, T_SHL, 32'h0, 32'h1);
      if (poke && c == 3) driveInputs(1'b0, op, ~a, ~b);
      if ((bus1.busy && bus1.done) || (bus4.busy && bus4.done)) overlap = 1'b1;
      if (!seen1 && bus1.done) begin
        seen1 = 1'b1;
        e = q1.pop_front();
        checkOutput("s1_result", bus1.result, e.res);
        checkOutput("s1_illegal", {31'b0, bus1.illegal_op}, {31'b0, e.ill});
        checkOutput("s1_latency", c, e.lat);
      end
      if (!seen4 && bus4.done) begin
        seen4 = 1'b1;
        e = q4.pop_front();
        checkOutput("s4_result", bus4.result, e.res);
        checkOutput("s4_illegal", {31'b0, bus4.illegal_op}, {31'b0, e.ill});
        checkOutput("s4_latency", c, e.lat);
      end
    end
    checkOutput("s1_done_seen", {31'b0, seen1}, 32'h1);
    checkOutput("s4_done_seen", {31'b0, seen4}, 32'h1);
    checkOutput("busy_done_overlap", {31'b0, overlap}, 32'h0);
    if (!seen1) void'(q1.pop_front());
    if (!seen4) void'(q4.pop_front());
    @(negedge Clock);
    checkOutput("s1_done_pulse", {31'b0, bus1.done}, 32'h0);
  endtask

  initial begin
    logic [4:0] ops[5];
    ops = '{T_SHR, T_SHL, T_SHRA, T_ROR, T_ROL};
    Clear = 1'b1;
    driveInputs(1'b0, 5'h0, 32'h0, 32'h0);
    repeat (2) @(negedge Clock);
    checkOutput("rst_result", bus1.result, 32'h0);
    checkOutput("rst_busy", {31'b0, bus1.busy}, 32'h0);
    checkOutput("rst_done", {31'b0, bus4.done}, 32'h0);
    checkOutput("rst_illegal", {31'b0, bus4.illegal_op}, 32'h0);
    Clear = 1'b0;

    applyStimulus(T_SHRA, 32'hFEDB_CA98, 32'd10, 1'b0);
    applyStimulus(T_ROL,  32'h8000_0001, 32'd4,  1'b0);
    applyStimulus(T_SHL,  32'h0000_000F, 32'd0,  1'b0);
    applyStimulus(5'b00011, 32'h1234_5678, 32'd7, 1'b0);
    applyStimulus(T_ROR,  32'h1234_5678, 32'd16, 1'b1);
    applyStimulus(T_SHR,  32'h8000_0000, 32'd32, 1'b0);
    applyStimulus(T_SHRA, 32'h8000_0010, 32'd40, 1'b0);
    applyStimulus(T_ROL,  32'hA5A5_0F0F, 32'd35, 1'b0);

    // Abort a long shift with Clear and confirm everything returns to reset.
    @(negedge Clock);
    driveInputs(1'b1, T_SHR, 32'hFFFF_FFFF, 32'd20);
    @(negedge Clock);
    driveInputs(1'b0, T_SHR, 32'h0, 32'h0);
    repeat (2) @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    checkOutput("clr_result", bus1.result, 32'h0);
    checkOutput("clr_busy1", {31'b0, bus1.busy}, 32'h0);
    checkOutput("clr_busy4", {31'b0, bus4.busy}, 32'h0);
    checkOutput("clr_done", {31'b0, bus1.done}, 32'h0);
    applyStimulus(T_SHR, 32'h8000_0000, 32'd31, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(ops[i % 5], $urandom, 32'($urandom_range(0, 40)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
